// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the FSM state, register ids and the control bundle.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } hazard_state_t;

   // en/fl bit 3 = IF/ID, 2 = ID/EX, 1 = EX/MEM, 0 = MEM/WB
   typedef struct packed {
      logic       pc_en;
      logic [3:0] en;
      logic [3:0] fl;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_OFF = 9'b0_0000_0000;
   localparam hz_ctrl_t CTRL_RUN = 9'b1_1111_0000;
   localparam hz_ctrl_t CTRL_DST = 9'b0_0001_0001;
   localparam hz_ctrl_t CTRL_RDR = 9'b1_1111_1110;
   localparam hz_ctrl_t CTRL_LU  = 9'b0_0111_0100;
   localparam hz_ctrl_t CTRL_NOI = 9'b0_1111_1000;

   function automatic logic load_use(
      input logic     rd,
      input regbits_t rt_ex,
      input regbits_t rs_id,
      input regbits_t rt_id
   );
      return rd && (rt_ex != '0) &&
             ((rt_ex == rs_id) || (rt_ex == rt_id));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the datapath.
// Modport hazard_ctrl is the block, tb is the driving side.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   import cpu_types_pkg::*;

   logic             ihit;
   logic             dhit;
   logic             dmemREN_EX_MEM;
   logic             dmemWEN_EX_MEM;
   logic             memRead_ID_EX;
   regbits_t         Rt_ID_EX;
   regbits_t         Rs_IF_ID;
   regbits_t         Rt_IF_ID;
   logic             redirect_EX_MEM;
   logic             halt_EX_MEM;
   logic             pc_en;
   logic             enable_IF_ID;
   logic             enable_ID_EX;
   logic             enable_EX_MEM;
   logic             enable_MEM_WB;
   logic             flush_IF_ID;
   logic             flush_ID_EX;
   logic             flush_EX_MEM;
   logic             flush_MEM_WB;
   logic             halted;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport hazard_ctrl (
      input  ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM,
      input  memRead_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
      input  redirect_EX_MEM, halt_EX_MEM,
      output pc_en,
      output enable_IF_ID, enable_ID_EX,
      output enable_EX_MEM, enable_MEM_WB,
      output flush_IF_ID, flush_ID_EX,
      output flush_EX_MEM, flush_MEM_WB,
      output halted, mem_timeout,
      output stall_count, flush_count
   );

   modport tb (
      output ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM,
      output memRead_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
      output redirect_EX_MEM, halt_EX_MEM,
      input  pc_en,
      input  enable_IF_ID, enable_ID_EX,
      input  enable_EX_MEM, enable_MEM_WB,
      input  flush_IF_ID, flush_ID_EX,
      input  flush_EX_MEM, flush_MEM_WB,
      input  halted, mem_timeout,
      input  stall_count, flush_count
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counters.sv
// Stall and flush event counters for the hazard controller.
// Both wrap naturally and hold while freeze is high.
module perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             freeze,
   input  logic             inc_stall,
   input  logic             inc_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // count qualifying events unless frozen
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_count <= '0;
         flush_count <= '0;
      end else if (!freeze) begin
         if (inc_stall) stall_count <= stall_count + 1'b1;
         if (inc_flush) flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Also drains on halt and watches data-memory wait time.
module pipeline_hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input logic             CLK,
   input logic             nRST,
   hazard_ctrl_if.hazard_ctrl hif
);

   localparam int WW = $clog2(TIMEOUT) + 1;
   localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

   hazard_state_t  state;
   hz_ctrl_t       ctrl;
   logic           dstall;
   logic           lu;
   logic           take_rdr;
   logic           halted_q;
   logic           mem_timeout_q;
   logic [WW-1:0]  wait_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   assign dstall = (hif.dmemREN_EX_MEM | hif.dmemWEN_EX_MEM)
                 & ~hif.dhit;
   assign lu = load_use(hif.memRead_ID_EX, hif.Rt_ID_EX,
                        hif.Rs_IF_ID, hif.Rt_IF_ID);

   // first matching hazard rule picks the control pattern
   always_comb begin
      ctrl     = CTRL_RUN;
      take_rdr = 1'b0;
      priority case (1'b1)
         (state == HALTED): ctrl = CTRL_OFF;
         dstall:            ctrl = CTRL_DST;
         hif.redirect_EX_MEM: begin
            ctrl     = CTRL_RDR;
            take_rdr = 1'b1;
         end
         lu:                ctrl = CTRL_LU;
         !hif.ihit:         ctrl = CTRL_NOI;
         default:           ctrl = CTRL_RUN;
      endcase
   end

   assign hif.pc_en         = ctrl.pc_en;
   assign hif.enable_IF_ID  = ctrl.en[3];
   assign hif.enable_ID_EX  = ctrl.en[2];
   assign hif.enable_EX_MEM = ctrl.en[1];
   assign hif.enable_MEM_WB = ctrl.en[0];
   assign hif.flush_IF_ID   = ctrl.fl[3];
   assign hif.flush_ID_EX   = ctrl.fl[2];
   assign hif.flush_EX_MEM  = ctrl.fl[1];
   assign hif.flush_MEM_WB  = ctrl.fl[0];

   // sequencer state, sticky flags and memory watchdog
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state         <= RUN;
         halted_q      <= 1'b0;
         mem_timeout_q <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (dstall) begin
                  state <= DWAIT;
               end else if (hif.halt_EX_MEM) begin
                  state    <= HALTED;
                  halted_q <= 1'b1;
               end
            end
            DWAIT:   if (!dstall) state <= RUN;
            HALTED:  state <= HALTED;
            default: state <= RUN;
         endcase
         if (state != HALTED) begin
            if (dstall) begin
               if (wait_cnt == WAIT_MAX)
                  mem_timeout_q <= 1'b1;
               else
                  wait_cnt <= wait_cnt + 1'b1;
            end else begin
               wait_cnt <= '0;
            end
         end
      end
   end

   assign hif.halted      = halted_q;
   assign hif.mem_timeout = mem_timeout_q;

   perf_counters #(
      .CNT_W (CNT_W)
   ) u_perf (
      .CLK         (CLK),
      .nRST        (nRST),
      .freeze      (state == HALTED),
      .inc_stall   (~ctrl.pc_en & (state != HALTED)),
      .inc_flush   (take_rdr),
      .stall_count (stall_cnt),
      .flush_count (flush_cnt)
   );

   assign hif.stall_count = stall_cnt;
   assign hif.flush_count = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Control patterns go through an expected-value queue.
module tb_pipeline_hazard_ctrl;
   import cpu_types_pkg::*;

   localparam logic [8:0] C_RUN = 9'b1_1111_0000;
   localparam logic [8:0] C_LU  = 9'b0_0111_0100;
   localparam logic [8:0] C_DST = 9'b0_0001_0001;
   localparam logic [8:0] C_RDR = 9'b1_1111_1110;
   localparam logic [8:0] C_NOI = 9'b0_1111_1000;
   localparam logic [8:0] C_OFF = 9'b0_0000_0000;

   logic        clk = 1'b0;
   logic        nrst;
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_stall = 0;
   logic [31:0] exp_flush = 0;
   logic        exp_halted = 1'b0;
   logic [8:0]  exp_q[$];
   string       tag_q[$];

   hazard_ctrl_if #(.CNT_W(32)) hif();

   pipeline_hazard_ctrl #(
      .TIMEOUT (4),
      .CNT_W   (32)
   ) dut (
      .CLK  (clk),
      .nRST (nrst),
      .hif  (hif)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ctrl_now();
      return {hif.pc_en,
              hif.enable_IF_ID, hif.enable_ID_EX,
              hif.enable_EX_MEM, hif.enable_MEM_WB,
              hif.flush_IF_ID, hif.flush_ID_EX,
              hif.flush_EX_MEM, hif.flush_MEM_WB};
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [8:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      if (!e[8] && !exp_halted) exp_stall++;
      if (e == C_RDR) exp_flush++;
   endtask

   task automatic cyc(input string tag, input logic [8:0] e);
      string t;
      logic [8:0] x;
      push(tag, e);
      @(negedge clk);
      t = tag_q.pop_front();
      x = exp_q.pop_front();
      chk(t, 32'(ctrl_now()), 32'(x));
      @(posedge clk);
      #1;
   endtask

   initial begin
      nrst = 1'b0;
      hif.ihit = 1'b1;
      hif.dhit = 1'b0;
      hif.dmemREN_EX_MEM = 1'b0;
      hif.dmemWEN_EX_MEM = 1'b0;
      hif.memRead_ID_EX = 1'b0;
      hif.Rt_ID_EX = '0;
      hif.Rs_IF_ID = '0;
      hif.Rt_IF_ID = '0;
      hif.redirect_EX_MEM = 1'b0;
      hif.halt_EX_MEM = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctrl", 32'(ctrl_now()), 32'(C_RUN));
      chk("rst_state", 32'(dut.state), 32'(RUN));
      chk("rst_stall", hif.stall_count, 32'd0);
      chk("rst_flush", hif.flush_count, 32'd0);
      chk("rst_halted", 32'(hif.halted), 32'd0);
      chk("rst_tmo", 32'(hif.mem_timeout), 32'd0);
      nrst = 1'b1;

      hif.memRead_ID_EX = 1'b1;
      hif.Rt_ID_EX = 5'd5;
      hif.Rs_IF_ID = 5'd5;
      cyc("lu_rs", C_LU);
      chk("lu_stall_cnt", hif.stall_count, 32'd1);
      hif.Rs_IF_ID = 5'd0;
      hif.Rt_IF_ID = 5'd5;
      cyc("lu_rt", C_LU);
      hif.Rt_ID_EX = 5'd0;
      hif.Rt_IF_ID = 5'd0;
      cyc("lu_r0", C_RUN);
      hif.memRead_ID_EX = 1'b0;
      hif.Rt_ID_EX = 5'd5;
      hif.Rs_IF_ID = 5'd5;
      cyc("no_load", C_RUN);
      hif.Rt_ID_EX = 5'd0;
      hif.Rs_IF_ID = 5'd0;

      hif.dmemWEN_EX_MEM = 1'b1;
      cyc("st_w1", C_DST);
      chk("st_dwait", 32'(dut.state), 32'(DWAIT));
      cyc("st_w2", C_DST);
      cyc("st_w3", C_DST);
      hif.dhit = 1'b1;
      cyc("st_hit", C_RUN);
      chk("st_run", 32'(dut.state), 32'(RUN));
      hif.dmemWEN_EX_MEM = 1'b0;
      hif.dhit = 1'b0;
      chk("st_stall_cnt", hif.stall_count, exp_stall);

      hif.ihit = 1'b0;
      hif.redirect_EX_MEM = 1'b1;
      cyc("rdr_noi", C_RDR);
      hif.redirect_EX_MEM = 1'b0;
      cyc("noi", C_NOI);
      hif.ihit = 1'b1;
      chk("rdr_flush_cnt", hif.flush_count, 32'd1);

      hif.dmemREN_EX_MEM = 1'b1;
      hif.redirect_EX_MEM = 1'b1;
      cyc("rdr_dst1", C_DST);
      cyc("rdr_dst2", C_DST);
      hif.dhit = 1'b1;
      cyc("rdr_hit", C_RDR);
      hif.dmemREN_EX_MEM = 1'b0;
      hif.dhit = 1'b0;
      hif.redirect_EX_MEM = 1'b0;
      chk("rdr_dst_flush", hif.flush_count, exp_flush);

      hif.redirect_EX_MEM = 1'b1;
      hif.memRead_ID_EX = 1'b1;
      hif.Rt_ID_EX = 5'd7;
      hif.Rs_IF_ID = 5'd7;
      cyc("rdr_lu", C_RDR);
      hif.redirect_EX_MEM = 1'b0;
      hif.dmemREN_EX_MEM = 1'b1;
      cyc("dst_lu", C_DST);
      hif.dhit = 1'b1;
      cyc("lu_after", C_LU);
      hif.dmemREN_EX_MEM = 1'b0;
      hif.dhit = 1'b0;
      hif.memRead_ID_EX = 1'b0;
      hif.Rt_ID_EX = 5'd0;
      hif.Rs_IF_ID = 5'd0;
      chk("mix_stall", hif.stall_count, exp_stall);
      chk("mix_flush", hif.flush_count, exp_flush);

      hif.dmemWEN_EX_MEM = 1'b1;
      cyc("tmo_w1", C_DST);
      cyc("tmo_w2", C_DST);
      cyc("tmo_w3", C_DST);
      chk("tmo_not_yet", 32'(hif.mem_timeout), 32'd0);
      cyc("tmo_w4", C_DST);
      chk("tmo_set", 32'(hif.mem_timeout), 32'd1);
      hif.dhit = 1'b1;
      cyc("tmo_hit", C_RUN);
      hif.dmemWEN_EX_MEM = 1'b0;
      hif.dhit = 1'b0;
      chk("tmo_sticky", 32'(hif.mem_timeout), 32'd1);

      hif.halt_EX_MEM = 1'b1;
      cyc("halt_acc", C_RUN);
      exp_halted = 1'b1;
      hif.halt_EX_MEM = 1'b0;
      chk("halted_set", 32'(hif.halted), 32'd1);
      chk("halted_state", 32'(dut.state), 32'(HALTED));
      hif.redirect_EX_MEM = 1'b1;
      hif.ihit = 1'b0;
      cyc("halted_off", C_OFF);
      chk("halt_stall_frz", hif.stall_count, exp_stall);
      chk("halt_flush_frz", hif.flush_count, exp_flush);
      hif.redirect_EX_MEM = 1'b0;
      hif.ihit = 1'b1;

      #2;
      nrst = 1'b0;
      #1;
      exp_stall = 0;
      exp_flush = 0;
      exp_halted = 1'b0;
      chk("rst2_state", 32'(dut.state), 32'(RUN));
      chk("rst2_halted", 32'(hif.halted), 32'd0);
      chk("rst2_tmo", 32'(hif.mem_timeout), 32'd0);
      chk("rst2_stall", hif.stall_count, 32'd0);
      chk("rst2_flush", hif.flush_count, 32'd0);
      chk("rst2_ctrl", 32'(ctrl_now()), 32'(C_RUN));
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      cyc("post_rst", C_RUN);
      chk("post_rst_stall", hif.stall_count, exp_stall);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central sequencer for the five-stage pipeline: each cycle it decides which pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC advance, hold, or load a bubble. It also drains the pipeline on halt, tracks data-memory wait cycles with a watchdog, and keeps stall and flush performance counters. It sits beside the datapath and drives the `enable_*` and `flush_*` inputs of every pipeline register.

## Interface
Parameters:
- `TIMEOUT`, default 1024: consecutive data-memory wait cycles before `mem_timeout` sets.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  instruction fetch complete this cycle.
- `dhit`  in  1  data access complete this cycle.
- `dmemREN_EX_MEM`, `dmemWEN_EX_MEM`  in  1 each  load or store held in EX/MEM.
- `memRead_ID_EX`  in  1  instruction in ID/EX is a load.
- `Rt_ID_EX`  in  5 (`regbits_t`)  load destination register.
- `Rs_IF_ID`, `Rt_IF_ID`  in  5 each  source registers of the decoding instruction.
- `redirect_EX_MEM`  in  1  taken branch or jump held in EX/MEM; PC must load its target.
- `halt_EX_MEM`  in  1  halt instruction held in EX/MEM.
- `pc_en`  out  1  PC loads the next or target address.
- `enable_IF_ID`, `enable_ID_EX`, `enable_EX_MEM`, `enable_MEM_WB`  out  1 each  register captures its input.
- `flush_IF_ID`, `flush_ID_EX`, `flush_EX_MEM`, `flush_MEM_WB`  out  1 each  register captures a bubble (all zero). Flush overrides data but acts only when the matching enable=1.
- `halted`  out  1  pipeline drained after halt; sticky.
- `mem_timeout`  out  1  watchdog tripped; sticky.
- `stall_count`  out  `CNT_W`  cycles in which `pc_en`=0 while not halted.
- `flush_count`  out  `CNT_W`  redirect events taken.

## Operation
- FSM states are `RUN`, `DWAIT` and `HALTED`; reset enters `RUN`.
- Derived terms:
  - `dstall` = (`dmemREN_EX_MEM` | `dmemWEN_EX_MEM`) & ~`dhit`.
  - `lu` = `memRead_ID_EX` & (`Rt_ID_EX`≠0) & (`Rt_ID_EX`==`Rs_IF_ID` | `Rt_ID_EX`==`Rt_IF_ID`).
- In `RUN` and `DWAIT`, the first matching rule wins:
  1. `dstall`: `pc_en`=0; IF/ID, ID/EX and EX/MEM enables=0; `enable_MEM_WB`=1 with `flush_MEM_WB`=1. Any redirect or halt in EX/MEM is held and re-presented.
  2. `redirect_EX_MEM`: all enables=1, `pc_en`=1 regardless of `ihit`; `flush_IF_ID`, `flush_ID_EX` and `flush_EX_MEM`=1; `flush_count` increments.
  3. `lu`: `pc_en`=0, `enable_IF_ID`=0; `enable_ID_EX`=1 with `flush_ID_EX`=1; EX/MEM and MEM/WB enabled.
  4. ~`ihit`: `pc_en`=0; `enable_IF_ID`=1 with `flush_IF_ID`=1; the rest enabled.
  5. Otherwise: all enables=1, no flushes, `pc_en`=1.
- State transitions:
  - `RUN`→`DWAIT` when `dstall`.
  - `DWAIT`→`RUN` on the cycle after `dhit`. The access completes and EX/MEM advances in the same cycle `dhit` is seen.
  - `RUN`→`HALTED` when `halt_EX_MEM` & ~`dstall`, so that MEM/WB captures the halt on that edge.
  - `HALTED` is exited only by `nRST`.
- In `HALTED`: every enable, flush and `pc_en` is 0, and `halted`=1.
- Watchdog:
  - `wait_cnt` increments each cycle `dstall`=1 and clears when `dstall`=0.
  - When `wait_cnt` reaches `TIMEOUT`−1 while `dstall`=1, `mem_timeout` sets; it does not alter the stall.
- Counters wrap modulo 2^`CNT_W` and are frozen in `HALTED`.

## Timing
- `pc_en`, enables and flushes are combinational from the current state and inputs, with zero-cycle latency.
- `halted`, `mem_timeout`, `stall_count`, `flush_count` and `wait_cnt` are registered.
- Reset values: state `RUN`, `halted`=0, `mem_timeout`=0, both counters 0, `wait_cnt`=0.
- During reset the combinational outputs follow `RUN` rules. The pipeline registers are reset by the same `nRST`.
- Simultaneous events:
  - `dstall` with a redirect: the redirect is delayed until `dhit`.
  - `dstall` with `lu`: the whole pipeline freezes, and `lu` re-evaluates afterwards.
  - Redirect with `lu`: the redirect wins and the dependent instruction is flushed.
- `halted` rises one cycle after `halt_EX_MEM` is accepted.
- Asserting `nRST` mid-wait clears `wait_cnt` and returns the FSM to `RUN`.

## Structure
- `hazard_state_t` (`RUN`/`DWAIT`/`HALTED`) lives in `cpu_types_pkg`.
- `hazard_ctrl_if.vh` declares the signals, with modport `hazard_ctrl` for this block and a `tb` modport for the bench.
- Sub-module `perf_counters` holds `stall_count` and `flush_count`, with a per-counter increment and a freeze input.

## Test plan
- Load to `$5` in ID/EX while IF/ID reads `$5` as `Rs` → one cycle with `pc_en`=0, `enable_IF_ID`=0 and `flush_ID_EX`=1; `stall_count`=1.
- Store in EX/MEM with `dhit` low for 3 cycles → `flush_MEM_WB`=1 and other enables 0 for 3 cycles; state `DWAIT`; advance on `dhit`; `stall_count`=3.
- `redirect_EX_MEM`=1 with `ihit`=0 → `pc_en`=1 and three flushes; `flush_count`=1.
- `redirect_EX_MEM` during a 2-cycle `dstall` → flushes appear only in the `dhit` cycle.
- `halt_EX_MEM`=1 → `halted`=1 next cycle and all outputs 0; pulse `nRST` low mid-`HALTED` → back to `RUN`, counters 0.
- `TIMEOUT`=4 with `dhit` held low → `mem_timeout`=1 after the 4th wait cycle and stays 1 after `dhit`.
